mbinit_sb_tx_arbiter: RTL and testbench



---
 rtl/mbinit_sb_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mbinit_sb_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_sb_tx_arbiter.sv
// mbinit_sb_tx_arbiter
//   Round-robin arbiter that shares the single sideband TX message channel
//   between the MBINIT sub-modules. Only one message is in flight at a time.
//   The granted message is latched and held until the sideband busy
//   handshake completes.
//
// Ports
//   CLK, rst_n      clock, asynchronous active-low reset
//   i_flush         synchronous abort back to IDLE (no done, pointer kept)
//   i_req_valid     per-requester level valid
//   i_req_msg       per-requester message code, slice k = [k*MSG_W +: MSG_W]
//   i_sb_busy       sideband TX busy
//   o_sb_valid      one-cycle message strobe to the sideband encoder
//   o_sb_msg        latched message of the current transaction
//   o_grant         one-hot owner of the current transaction
//   o_done          one-hot, one-cycle completion pulse for the owner
//   o_timeout_err   one-cycle pulse when busy never asserts (optional)
//
// Optional feature: define SB_ARB_TIMEOUT_EN to abort a transaction when
// i_sb_busy has not asserted within TIMEOUT_CYC cycles of WAIT_BUSY.
module mbinit_sb_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MSG_W       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*MSG_W-1:0] i_req_msg,
  input  logic                   i_sb_busy,
  output logic                   o_sb_valid,
  output logic [MSG_W-1:0]       o_sb_msg,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done
`ifdef SB_ARB_TIMEOUT_EN
  ,
  output logic                   o_timeout_err
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                        state, state_nxt;
  logic                          busy_d, fall;
  logic [IDX_W-1:0]              ptr, ptr_nxt, win, win_nxt, arb_idx;
  logic                          arb_hit;
  logic [IDX_W:0]                scan;
  logic [N_REQ-1:0][MSG_W-1:0]   msg_arr;
  logic                          sb_valid_nxt;
  logic [MSG_W-1:0]              msg_nxt;
  logic [N_REQ-1:0]              grant_nxt, done_nxt;

  assign msg_arr = i_req_msg;
  assign fall    = busy_d & ~i_sb_busy;

`ifdef SB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo, err_nxt;

  // Counter is held at zero outside WAIT_BUSY, so it starts from zero on entry.
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n)                  cnt <= '0;
    else if (state != WAIT_BUSY) cnt <= '0;
    else                         cnt <= cnt + 1'b1;

  // Fires on the TIMEOUT_CYC-th WAIT_BUSY cycle without busy.
  assign tmo = (state == WAIT_BUSY) && !i_sb_busy && !fall &&
               (cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // Rotating priority: first valid scanning upward from ptr+1, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    scan    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan = {1'b0, ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(N_REQ)) scan = scan - (IDX_W+1)'(N_REQ);
      if (!arb_hit && i_req_valid[scan[IDX_W-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = scan[IDX_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (i_flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:      if (arb_hit && !i_sb_busy) state_nxt = ISSUE;
        ISSUE:     state_nxt = WAIT_BUSY;
        WAIT_BUSY: begin
          if (i_sb_busy) state_nxt = WAIT_DONE;
          else if (fall) state_nxt = IDLE;   // busy pulse already came and went
`ifdef SB_ARB_TIMEOUT_EN
          else if (tmo)  state_nxt = IDLE;
`endif
        end
        WAIT_DONE: if (fall) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs and bookkeeping
  always_comb begin
    sb_valid_nxt = 1'b0;
    msg_nxt      = o_sb_msg;
    grant_nxt    = o_grant;
    done_nxt     = '0;
    win_nxt      = win;
    ptr_nxt      = ptr;
`ifdef SB_ARB_TIMEOUT_EN
    err_nxt      = 1'b0;
`endif
    if (i_flush) grant_nxt = '0;
    else begin
      case (state)
        IDLE: if (state_nxt == ISSUE) begin
          sb_valid_nxt = 1'b1;
          win_nxt      = arb_idx;
          msg_nxt      = msg_arr[arb_idx];
          grant_nxt    = N_REQ'(1) << arb_idx;
        end
        ISSUE: ;
        WAIT_BUSY: begin
          if (!i_sb_busy && fall) begin
            done_nxt  = o_grant;
            grant_nxt = '0;
            ptr_nxt   = win;
          end
`ifdef SB_ARB_TIMEOUT_EN
          else if (tmo) begin
            err_nxt   = 1'b1;
            grant_nxt = '0;
            ptr_nxt   = win;
          end
`endif
        end
        WAIT_DONE: if (fall) begin
          done_nxt  = o_grant;
          grant_nxt = '0;
          ptr_nxt   = win;
        end
        default: grant_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      o_sb_valid <= 1'b0;
      o_sb_msg   <= '0;
      o_grant    <= '0;
      o_done     <= '0;
      win        <= '0;
      ptr        <= IDX_W'(N_REQ - 1);
      busy_d     <= 1'b0;
    end else begin
      o_sb_valid <= sb_valid_nxt;
      o_sb_msg   <= msg_nxt;
      o_grant    <= grant_nxt;
      o_done     <= done_nxt;
      win        <= win_nxt;
      ptr        <= ptr_nxt;
      busy_d     <= i_sb_busy;
    end

`ifdef SB_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) o_timeout_err <= 1'b0;
    else        o_timeout_err <= err_nxt;
`endif

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Directed bench for mbinit_sb_tx_arbiter (N_REQ=4, MSG_W=4, TIMEOUT_CYC=8).
// Inputs change 1 ns after the rising edge; outputs are checked at that point,
// i.e. they reflect the edge just taken.
module tb_mbinit_sb_tx_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_flush = 1'b0;
  logic [N-1:0]   i_req_valid = '0;
  logic [N*W-1:0] i_req_msg = '0;
  logic           i_sb_busy = 1'b0;
  logic           o_sb_valid;
  logic [W-1:0]   o_sb_msg;
  logic [N-1:0]   o_grant, o_done;
`ifdef SB_ARB_TIMEOUT_EN
  logic           o_timeout_err;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  mbinit_sb_tx_arbiter #(.N_REQ(N), .MSG_W(W), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_flush(i_flush), .i_req_valid(i_req_valid),
    .i_req_msg(i_req_msg), .i_sb_busy(i_sb_busy), .o_sb_valid(o_sb_valid),
    .o_sb_msg(o_sb_msg), .o_grant(o_grant), .o_done(o_done)
`ifdef SB_ARB_TIMEOUT_EN
    , .o_timeout_err(o_timeout_err)
`endif
  );

  // {valid, msg, grant, done}
  wire [12:0] obs = {o_sb_valid, o_sb_msg, o_grant, o_done};

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_req_valid = '0; i_req_msg = '0; i_sb_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req_valid = 4'b1111; i_sb_busy = 1'b0;
    tick();
    nvec++;
    if (obs !== 13'b0) begin
      nerr++; $display("FAIL reset_outputs: got %b want %b", obs, 13'b0);
    end
`ifdef SB_ARB_TIMEOUT_EN
    nvec++;
    if (o_timeout_err !== 1'b0) begin
      nerr++; $display("FAIL reset_err: got %b want 0", o_timeout_err);
    end
`endif
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    i_req_valid = 4'b0100; i_req_msg[2*W +: W] = 4'h3;
    tick();                                   // strobe
    nvec++;
    if (obs !== {1'b1, 4'h3, 4'b0100, 4'b0000}) begin
      nerr++; $display("FAIL single_issue: got %b want %b", obs, {1'b1, 4'h3, 4'b0100, 4'b0000});
    end
    tick();                                   // WAIT_BUSY
    nvec++;
    if (obs !== {1'b0, 4'h3, 4'b0100, 4'b0000}) begin
      nerr++; $display("FAIL single_wait: got %b want %b", obs, {1'b0, 4'h3, 4'b0100, 4'b0000});
    end
    i_sb_busy = 1'b1;
    tick(); tick(); tick();
    nvec++;
    if (obs !== {1'b0, 4'h3, 4'b0100, 4'b0000}) begin
      nerr++; $display("FAIL single_busy: got %b want %b", obs, {1'b0, 4'h3, 4'b0100, 4'b0000});
    end
    i_sb_busy = 1'b0;
    tick();                                   // fall seen
    nvec++;
    if (obs !== {1'b0, 4'h3, 4'b0000, 4'b0100}) begin
      nerr++; $display("FAIL single_done: got %b want %b", obs, {1'b0, 4'h3, 4'b0000, 4'b0100});
    end
    i_req_valid = '0;
    tick();
    nvec++;
    if (obs !== {1'b0, 4'h3, 4'b0000, 4'b0000}) begin
      nerr++; $display("FAIL single_idle: got %b want %b", obs, {1'b0, 4'h3, 4'b0000, 4'b0000});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] m;
    apply_reset();
    i_req_valid = 4'b1111;
    i_req_msg   = {4'h4, 4'h3, 4'h2, 4'h1};
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << (n % 4);
      m = 4'((n % 4) + 1);
      tick();
      nvec++;
      if (obs !== {1'b1, m, g, 4'b0000}) begin
        nerr++; $display("FAIL rr_issue%0d: got %b want %b", n, obs, {1'b1, m, g, 4'b0000});
      end
      tick();
      i_sb_busy = 1'b1; tick();
      i_sb_busy = 1'b0; tick();
      nvec++;
      if (obs !== {1'b0, m, 4'b0000, g}) begin
        nerr++; $display("FAIL rr_done%0d: got %b want %b", n, obs, {1'b0, m, 4'b0000, g});
      end
    end
    i_req_valid = '0;
    tick();
  endtask

  task automatic test_msg_hold();
    apply_reset();
    i_req_valid = 4'b0010; i_req_msg[1*W +: W] = 4'h5;
    tick();
    nvec++;
    if (obs !== {1'b1, 4'h5, 4'b0010, 4'b0000}) begin
      nerr++; $display("FAIL hold_issue: got %b want %b", obs, {1'b1, 4'h5, 4'b0010, 4'b0000});
    end
    tick();
    i_sb_busy = 1'b1; tick();                 // WAIT_DONE
    i_req_valid = 4'b0000; i_req_msg[1*W +: W] = 4'hF;
    tick();
    nvec++;
    if (obs !== {1'b0, 4'h5, 4'b0010, 4'b0000}) begin
      nerr++; $display("FAIL hold_mid: got %b want %b", obs, {1'b0, 4'h5, 4'b0010, 4'b0000});
    end
    i_sb_busy = 1'b0; tick();
    nvec++;
    if (obs !== {1'b0, 4'h5, 4'b0000, 4'b0010}) begin
      nerr++; $display("FAIL hold_done: got %b want %b", obs, {1'b0, 4'h5, 4'b0000, 4'b0010});
    end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    i_req_msg = {4'h9, 4'h7, 4'h6, 4'h0};
    // requester 1 completes, pointer becomes 1
    i_req_valid = 4'b0010;
    tick(); tick();
    i_sb_busy = 1'b1; tick();
    i_sb_busy = 1'b0; tick();
    nvec++;
    if (o_done !== 4'b0010) begin
      nerr++; $display("FAIL flush_pre_done: got %b want %b", o_done, 4'b0010);
    end
    i_req_valid = 4'b0100;
    tick();
    nvec++;
    if (obs !== {1'b1, 4'h7, 4'b0100, 4'b0000}) begin
      nerr++; $display("FAIL flush_issue2: got %b want %b", obs, {1'b1, 4'h7, 4'b0100, 4'b0000});
    end
    tick();
    i_sb_busy = 1'b1; tick();                 // WAIT_DONE, owner 2
    i_flush = 1'b1; tick();
    nvec++;
    if ({o_sb_valid, o_grant, o_done} !== 9'b0) begin
      nerr++; $display("FAIL flush_abort: got %b want %b", {o_sb_valid, o_grant, o_done}, 9'b0);
    end
    i_flush = 1'b0; i_sb_busy = 1'b0; i_req_valid = 4'b0000;
    tick();
    nvec++;
    if ({o_sb_valid, o_grant, o_done} !== 9'b0) begin
      nerr++; $display("FAIL flush_nodone: got %b want %b", {o_sb_valid, o_grant, o_done}, 9'b0);
    end
    i_req_valid = 4'b1100;
    tick();
    nvec++;
    if (obs !== {1'b1, 4'h7, 4'b0100, 4'b0000}) begin
      nerr++; $display("FAIL flush_resume: got %b want %b", obs, {1'b1, 4'h7, 4'b0100, 4'b0000});
    end
    i_flush = 1'b1; i_req_valid = '0; tick();
    i_flush = 1'b0; tick();
  endtask

  task automatic test_busy_hold();
    apply_reset();
    i_sb_busy = 1'b1; i_req_valid = 4'b0001; i_req_msg[0 +: W] = 4'hA;
    tick(); tick(); tick();
    nvec++;
    if ({o_sb_valid, o_grant} !== 5'b0) begin
      nerr++; $display("FAIL busyhold_wait: got %b want %b", {o_sb_valid, o_grant}, 5'b0);
    end
    i_sb_busy = 1'b0;
    tick();
    nvec++;
    if (obs !== {1'b1, 4'hA, 4'b0001, 4'b0000}) begin
      nerr++; $display("FAIL busyhold_issue: got %b want %b", obs, {1'b1, 4'hA, 4'b0001, 4'b0000});
    end
    tick();
    i_sb_busy = 1'b1; tick();
    i_sb_busy = 1'b0; tick();
    nvec++;
    if (o_done !== 4'b0001) begin
      nerr++; $display("FAIL busyhold_done: got %b want %b", o_done, 4'b0001);
    end
    i_req_valid = '0; tick();
  endtask

  // busy high only while ISSUE is being left: its fall lands in WAIT_BUSY
  task automatic test_short_busy();
    apply_reset();
    i_req_valid = 4'b1000; i_req_msg[3*W +: W] = 4'hC;
    tick();                                   // ISSUE
    i_sb_busy = 1'b1; tick();                 // WAIT_BUSY
    i_sb_busy = 1'b0; tick();
    nvec++;
    if (obs !== {1'b0, 4'hC, 4'b0000, 4'b1000}) begin
      nerr++; $display("FAIL short_done: got %b want %b", obs, {1'b0, 4'hC, 4'b0000, 4'b1000});
    end
    i_req_valid = '0; tick();
    nvec++;
    if (o_done !== 4'b0000) begin
      nerr++; $display("FAIL short_pulse: got %b want %b", o_done, 4'b0000);
    end
  endtask

`ifdef SB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    i_req_valid = 4'b0011; i_req_msg[0 +: W] = 4'h1; i_req_msg[1*W +: W] = 4'h2;
    tick();                                   // ISSUE, owner 0
    tick();                                   // WAIT_BUSY entry
    repeat (7) tick();
    nvec++;
    if ({o_timeout_err, o_grant} !== 5'b0_0001) begin
      nerr++; $display("FAIL tmo_before: got %b want %b", {o_timeout_err, o_grant}, 5'b0_0001);
    end
    tick();
    nvec++;
    if ({o_timeout_err, o_grant, o_done} !== 9'b1_0000_0000) begin
      nerr++; $display("FAIL tmo_pulse: got %b want %b", {o_timeout_err, o_grant, o_done}, 9'b1_0000_0000);
    end
    tick();
    nvec++;
    if ({o_timeout_err, obs} !== {1'b0, 1'b1, 4'h2, 4'b0010, 4'b0000}) begin
      nerr++; $display("FAIL tmo_next: got %b want %b", {o_timeout_err, obs}, {1'b0, 1'b1, 4'h2, 4'b0010, 4'b0000});
    end
    i_req_valid = '0; i_flush = 1'b1; tick();
    i_flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_msg_hold();
    test_flush();
    test_busy_hold();
    test_short_busy();
`ifdef SB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
